// File: rtl/vga_scanout.sv
// VGA raster scan-out: free-running h/v counters, one 16-bit VRAM word fetched per 5 pixels,
// three-stage pixel/sync pipeline so colour and sync leave the block aligned and registered.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] vram_address,
    output logic        vram_chipselect,
    input  logic [15:0] vram_readdata,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = (H_TOTAL > 1024) ? $clog2(H_TOTAL) : 10;
    localparam int VW = (V_TOTAL > 1024) ? $clog2(V_TOTAL) : 10;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [2:0]    phase;
    logic [6:0]    col;
    logic          visible;
    logic          hsync_on;
    logic          vsync_on;
    logic          fetch;
    logic [15:0]   addr_hold;
    logic          load;
    logic          vis_d1;
    logic          vis_d2;
    logic          hs_d1;
    logic          hs_d2;
    logic          vs_d1;
    logic          vs_d2;
    logic [15:0]   word;

    // phase tracks h_cnt % 5 and col tracks h_cnt / 5, avoiding a divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
            phase <= '0;
            col   <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            phase <= '0;
            col   <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
            if (phase == 3'd4) begin
                phase <= '0;
                col   <= col + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    always_comb begin
        visible         = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_on        = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        vsync_on        = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        fetch           = !reset && visible && (phase == 3'd0);
        vram_chipselect = fetch;
        vram_address    = fetch ? {v_cnt[8:0], col} : addr_hold;
        frame_start     = !reset && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_hold <= '0;
        end else if (fetch) begin
            addr_hold <= vram_address;
        end
    end

    // Stage 1: RAM data in flight; stage 2: word register; stage 3: output registers.
    // The word shifts 3 bits per clock, so the next load lands as pixel 4 is emitted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load      <= 1'b0;
            vis_d1    <= 1'b0;
            vis_d2    <= 1'b0;
            hs_d1     <= 1'b0;
            hs_d2     <= 1'b0;
            vs_d1     <= 1'b0;
            vs_d2     <= 1'b0;
            word      <= '0;
            vga_r     <= 1'b0;
            vga_g     <= 1'b0;
            vga_b     <= 1'b0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            load      <= fetch;
            vis_d1    <= visible;
            vis_d2    <= vis_d1;
            hs_d1     <= hsync_on;
            hs_d2     <= hs_d1;
            vs_d1     <= vsync_on;
            vs_d2     <= vs_d1;
            word      <= load ? vram_readdata : {3'b000, word[15:3]};
            vga_r     <= vis_d2 & word[2];
            vga_g     <= vis_d2 & word[1];
            vga_b     <= vis_d2 & word[0];
            vga_hsync <= !hs_d2;
            vga_vsync <= !vs_d2;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster (60x27) so whole frames fit in a short run.
module tb_vga_scanout;

    localparam int HV  = 40;
    localparam int HF  = 4;
    localparam int HSW = 8;
    localparam int HB  = 8;
    localparam int VV  = 20;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] vram_address;
    logic        vram_chipselect;
    logic [15:0] vram_readdata = '0;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        frame_start;

    int mode = 0;
    int n_assert = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0]  rgb;
        logic        hs;
        logic        vs;
        logic        cs;
        logic        fs;
        logic [15:0] addr;
    } exp_t;

    exp_t sb[$];

    int m_h = 0;
    int m_v = 0;
    bit m_started = 0;
    int hist_h[4];
    int hist_v[4];
    bit hist_ok[4];
    logic [15:0] m_last_addr = '0;

    vga_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vram_address(vram_address),
        .vram_chipselect(vram_chipselect),
        .vram_readdata(vram_readdata),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .frame_start(frame_start)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] ram_word(input int m, input logic [15:0] a);
        logic [15:0] last;
        last = {9'(VV - 1), 7'(HV / 5 - 1)};
        case (m)
            0:       return {1'b0, a[14:0]};
            1:       return (a == last) ? 16'h7FFF : 16'h0000;
            default: return 16'h8000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (vram_chipselect) vram_readdata <= ram_word(mode, vram_address);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pushes this cycle's expected outputs after each rising edge.
    initial begin
        exp_t e;
        logic [15:0] w;
        int ph;
        int pv;
        forever begin
            @(posedge clk);
            #3;
            if (reset) begin
                m_started = 0;
                m_h = 0;
                m_v = 0;
            end else if (!m_started) begin
                m_started = 1;
                m_h = 0;
                m_v = 0;
            end else if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
            for (int i = 3; i > 0; i--) begin
                hist_h[i]  = hist_h[i-1];
                hist_v[i]  = hist_v[i-1];
                hist_ok[i] = hist_ok[i-1];
            end
            hist_h[0]  = m_h;
            hist_v[0]  = m_v;
            hist_ok[0] = !reset;

            e.fs = !reset && m_h == 0 && m_v == 0;
            e.cs = !reset && (m_h % 5 == 0) && m_h < HV && m_v < VV;
            if (reset) m_last_addr = '0;
            else if (e.cs) m_last_addr = {9'(m_v), 7'(m_h / 5)};
            e.addr = m_last_addr;

            if (reset || !hist_ok[3]) begin
                e.rgb = 3'b000;
                e.hs  = 1'b1;
                e.vs  = 1'b1;
            end else begin
                ph = hist_h[3];
                pv = hist_v[3];
                e.hs = !(ph >= HV + HF && ph < HV + HF + HSW);
                e.vs = !(pv >= VV + VF && pv < VV + VF + VSW);
                if (ph < HV && pv < VV) begin
                    w = ram_word(mode, {9'(pv), 7'(ph / 5)});
                    e.rgb = 3'((w >> (3 * (ph % 5))) & 16'h0007);
                end else begin
                    e.rgb = 3'b000;
                end
            end
            sb.push_back(e);
        end
    end

    // Monitor: pops one expectation per cycle and checks frame-level totals.
    initial begin
        exp_t e;
        bit tracking = 0;
        int period = 0;
        int hs_low = 0;
        int vs_low = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("rgb", {29'd0, vga_r, vga_g, vga_b}, {29'd0, e.rgb});
                chk("hsync", {31'd0, vga_hsync}, {31'd0, e.hs});
                chk("vsync", {31'd0, vga_vsync}, {31'd0, e.vs});
                chk("chipselect", {31'd0, vram_chipselect}, {31'd0, e.cs});
                chk("address", {16'd0, vram_address}, {16'd0, e.addr});
                chk("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
            end
            if (reset) begin
                tracking = 0;
            end else begin
                if (frame_start) begin
                    if (tracking) begin
                        chk("frame_period", 32'(period), 32'(FRAME));
                        chk("hsync_low_total", 32'(hs_low), 32'(HSW * VT));
                        chk("vsync_low_total", 32'(vs_low), 32'(VSW * HT));
                    end
                    tracking = 1;
                    period = 0;
                    hs_low = 0;
                    vs_low = 0;
                end
                period++;
                if (!vga_hsync) hs_low++;
                if (!vga_vsync) vs_low++;
            end
        end
    end

    task automatic do_reset(input int cycles, input int new_mode);
        @(posedge clk);
        #2 reset = 1'b1;
        mode = new_mode;
        repeat (cycles) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        mode  = 0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        repeat (FRAME + 100) @(posedge clk);

        // land the reset inside an active hsync pulse on a visible line
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(posedge clk);
            #4;
            if (m_h == HV + HF + HSW / 2 - 1 && m_v == 12) found = 1;
        end
        chk("midframe_wait", {31'd0, found}, 32'd1);
        do_reset(3, 0);
        repeat (200) @(posedge clk);

        do_reset(4, 1);
        repeat (FRAME + 100) @(posedge clk);

        do_reset(4, 2);
        repeat (FRAME + 100) @(posedge clk);

        repeat (3) @(posedge clk);
        #6;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
